// File: rtl/bbox_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module : bbox_scan_pkg
// Brief  : Shared constants, register map and FSM states for bbox_scan_ctrl.
// Rev    : 1.0
// ============================================================================
package bbox_scan_pkg;

    localparam int DEF_WIDTH       = 160;
    localparam int DEF_HEIGHT      = 90;
    localparam int FRAME_BYTES     = DEF_WIDTH * DEF_HEIGHT * 3;
    localparam int DEF_CLEAR_INDEX = 99999;
    localparam int IDX_W           = 24;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_RESULT = 2'd1;
    localparam logic [1:0] ADDR_BASE   = 2'd2;

    localparam int CTRL_START    = 0;
    localparam int CTRL_ABORT    = 1;
    localparam int CTRL_DONE_CLR = 2;
    localparam int CTRL_IE       = 3;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_IE    = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FETCH = 3'd2,
        DRAIN = 3'd3,
        LATCH = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bbox_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : bbox_scan_ctrl_if
// Brief  : Avalon-MM register slave bundle for bbox_scan_ctrl.
// Rev    : 1.0
// ============================================================================
interface bbox_scan_ctrl_if;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (output avs_address, output avs_read, output avs_write,
                    output avs_writedata, input avs_readdata);
    modport slave  (input avs_address, input avs_read, input avs_write,
                    input avs_writedata, output avs_readdata);
endinterface
`default_nettype wire

// File: rtl/bbox_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module : bbox_rd_pipe
// Brief  : DEPTH-stage {valid,index} delay line aligning indices with RAM data.
// Rev    : 1.0
// ============================================================================
module bbox_rd_pipe #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [23:0] in_index,
    output logic        out_valid,
    output logic [23:0] out_index,
    output logic        pending
);
    localparam logic [DEPTH-1:0] LAST_MASK = DEPTH'(1) << (DEPTH - 1);

    logic [DEPTH-1:0] valid;
    logic [23:0]      index [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) index[i] <= '0;
        end else if (flush) begin
            valid <= '0;
        end else begin
            valid[0] <= in_valid;
            index[0] <= in_index;
            for (int i = 1; i < DEPTH; i++) begin
                valid[i] <= valid[i-1];
                index[i] <= index[i-1];
            end
        end
    end

    assign out_valid = valid[DEPTH-1];
    assign out_index = index[DEPTH-1];
    // Pipe is empty next cycle once only the output stage may still hold data.
    assign pending   = |(valid & ~LAST_MASK);
endmodule
`default_nettype wire

// File: rtl/bbox_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : bbox_scan_ctrl
// Brief  : Clears the bbox engine, streams one frame into it, latches result.
//          Optional completion interrupt with macro BBOX_SCAN_IRQ_EN.
// Rev    : 1.0
// ============================================================================
module bbox_scan_ctrl
    import bbox_scan_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HEIGHT      = DEF_HEIGHT,
    parameter int RD_LATENCY  = 2,
    parameter int CLEAR_INDEX = DEF_CLEAR_INDEX
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    bbox_scan_ctrl_if.slave      avs,
    output logic [23:0]          mem_address,
    output logic                 mem_read,
    input  logic [7:0]           mem_readdata,
    output logic                 eng_wr_en,
    output logic [31:0]          eng_data,
    input  logic [31:0]          eng_out
`ifdef BBOX_SCAN_IRQ_EN
    ,
    output logic                 irq
`endif
);
    localparam logic [23:0] LAST_K       = 24'(WIDTH * HEIGHT * 3 - 1);
    localparam logic [31:0] EMPTY_RESULT = {8'(WIDTH - 1), 8'h00, 8'(HEIGHT - 1), 8'h00};

    state_t      state, state_nxt;
    logic [23:0] k;
    logic [23:0] frame_base;
    logic [31:0] result;
    logic        done;
    logic        ie_bit;
    logic        busy, ctrl_wr, start_cmd, abort_cmd, done_clr;
    logic        pipe_valid, pipe_pending;
    logic [23:0] pipe_index;

    assign busy      = (state != IDLE);
    assign ctrl_wr   = avs.avs_write && (avs.avs_address == ADDR_CTRL);
    assign start_cmd = ctrl_wr && avs.avs_writedata[CTRL_START] &&
                       !avs.avs_writedata[CTRL_ABORT] && !busy;
    assign abort_cmd = ctrl_wr && avs.avs_writedata[CTRL_ABORT] && busy;
    assign done_clr  = ctrl_wr && avs.avs_writedata[CTRL_DONE_CLR];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_read  = 1'b0;
        case (state)
            IDLE:    if (start_cmd) state_nxt = CLEAR;
            CLEAR:   state_nxt = FETCH;
            FETCH: begin
                mem_read = 1'b1;
                if (k == LAST_K) state_nxt = DRAIN;
            end
            DRAIN:   if (!pipe_pending) state_nxt = LATCH;
            LATCH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_cmd) state_nxt = IDLE;
    end

    bbox_rd_pipe #(.DEPTH(RD_LATENCY)) u_pipe (
        .clk       (CLOCK_50),
        .rst       (reset),
        .flush     (abort_cmd),
        .in_valid  (mem_read),
        .in_index  (k),
        .out_valid (pipe_valid),
        .out_index (pipe_index),
        .pending   (pipe_pending)
    );

    assign mem_address = mem_read ? (frame_base + k) : 24'h0;
    assign eng_wr_en   = pipe_valid;

    always_comb begin
        eng_data = 32'h0;
        if (state == CLEAR)  eng_data = {8'h00, 24'(CLEAR_INDEX)};
        else if (pipe_valid) eng_data = {mem_readdata, pipe_index};
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            k          <= '0;
            frame_base <= '0;
            result     <= '0;
            done       <= 1'b0;
        end else begin
            k <= (state == FETCH) ? k + 24'd1 : 24'd0;
            if (avs.avs_write && avs.avs_address == ADDR_BASE && !busy)
                frame_base <= avs.avs_writedata[23:0];
            if (start_cmd || done_clr) done <= 1'b0;
            if (state == LATCH && !abort_cmd) begin
                result <= eng_out;
                done   <= 1'b1;
            end
        end
    end

`ifdef BBOX_SCAN_IRQ_EN
    logic ie;
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)        ie <= 1'b0;
        else if (ctrl_wr) ie <= avs.avs_writedata[CTRL_IE];
    end
    assign ie_bit = ie;
    assign irq    = done && ie;
`else
    assign ie_bit = 1'b0;
`endif

    always_comb begin
        avs.avs_readdata = 32'h0;
        if (avs.avs_read) begin
            case (avs.avs_address)
                ADDR_CTRL: begin
                    avs.avs_readdata[STAT_BUSY]  = busy;
                    avs.avs_readdata[STAT_DONE]  = done;
                    avs.avs_readdata[STAT_EMPTY] = done && (result == EMPTY_RESULT);
                    avs.avs_readdata[STAT_IE]    = ie_bit;
                end
                ADDR_RESULT: avs.avs_readdata = result;
                ADDR_BASE:   avs.avs_readdata = {8'h00, frame_base};
                default:     avs.avs_readdata = 32'h0;
            endcase
        end
    end
endmodule
`default_nettype wire
